// File: rtl/rr_request_arb4.sv
// Round-robin arbiter for four edge-triggered request lines, feeding the 4-to-2 encoder.
// Each request is latched as a pending bit and granted one at a time over a valid/ready handshake.
module rr_request_arb4 #(
  parameter int RESET_PTR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r1,
  input  logic       r2,
  input  logic       r3,
  input  logic       r4,
  input  logic       ready,
  output logic       g1,
  output logic       g2,
  output logic       g3,
  output logic       g4,
  output logic       valid,
  output logic [3:0] pend,
  output logic       ovf
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state_reg, state_next;
  logic [3:0] rq_reg;
  logic [3:0] pend_reg, pend_next;
  logic       ovf_reg, ovf_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] g_reg, g_next;
  logic       valid_reg, valid_next;
  logic [1:0] gidx_reg, gidx_next;

  logic [3:0] req_vec;
  logic [3:0] edge_vec;
  logic [3:0] acc_vec;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;

  assign req_vec = {r4, r3, r2, r1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      assign edge_vec[gi] = req_vec[gi] & ~rq_reg[gi];
      assign acc_vec[gi]  = valid_reg & ready & g_reg[gi];
    end
  endgenerate

  // A new edge on a line being accepted this cycle re-arms it rather than overflowing.
  assign pend_next = (pend_reg & ~acc_vec) | edge_vec;
  assign ovf_next  = ovf_reg | (|(edge_vec & pend_reg & ~acc_vec));

  // Search only the registered pending bits, starting at ptr and wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_reg;
    cand      = ptr_reg;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_reg + 2'(k);
      if (!sel_found && pend_reg[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    valid_next = valid_reg;
    ptr_next   = ptr_reg;
    gidx_next  = gidx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          g_next     = 4'b0001 << sel_idx;
          valid_next = 1'b1;
          gidx_next  = sel_idx;
          state_next = ST_GRANT;
        end
      end
      default: begin
        // Grant is held untouched until the consumer takes it.
        if (ready) begin
          g_next     = 4'b0000;
          valid_next = 1'b0;
          ptr_next   = gidx_reg + 2'd1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      rq_reg    <= 4'b1111;
      pend_reg  <= 4'b0000;
      ovf_reg   <= 1'b0;
      ptr_reg   <= 2'(RESET_PTR);
      g_reg     <= 4'b0000;
      valid_reg <= 1'b0;
      gidx_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      rq_reg    <= req_vec;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
      ptr_reg   <= ptr_next;
      g_reg     <= g_next;
      valid_reg <= valid_next;
      gidx_reg  <= gidx_next;
    end
  end

  assign {g4, g3, g2, g1} = g_reg;
  assign valid = valid_reg;
  assign pend  = pend_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_rr_request_arb4.sv
// Directed bench for rr_request_arb4: edge capture, round-robin order, hold, overflow, reset.
module tb_rr_request_arb4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] r_drv = 4'b0000;
  logic       ready = 1'b0;
  logic       g1, g2, g3, g4, valid, ovf;
  logic [3:0] pend;
  logic [3:0] g;
  int         checks = 0;
  int         failures = 0;

  assign g = {g4, g3, g2, g1};

  always #5 clk = ~clk;

  rr_request_arb4 #(.RESET_PTR(0)) dut (
    .clk(clk), .rst(rst),
    .r1(r_drv[0]), .r2(r_drv[1]), .r3(r_drv[2]), .r4(r_drv[3]),
    .ready(ready),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4),
    .valid(valid), .pend(pend), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; r_drv = 4'b0000; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // One-hot invariant observed every cycle.
  always @(negedge clk) begin
    if (!rst)
      check("onehot_inv", ((valid && $onehot(g)) || (!valid && g == 4'b0000)) ? 32'd1 : 32'd0, 32'd1);
  end

  initial begin
    // Reset values
    rst = 1'b1; #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_g", {28'd0, g}, 32'd0);
    check("rst_pend", {28'd0, pend}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    do_reset();

    // Single r3 pulse: pend, grant, clear
    ready = 1'b1; r_drv = 4'b0100;
    step();
    check("t1_pend_e0", {28'd0, pend}, 32'h4);
    check("t1_valid_e0", {31'd0, valid}, 32'd0);
    r_drv = 4'b0000;
    step();
    check("t1_valid_e1", {31'd0, valid}, 32'd1);
    check("t1_g_e1", {28'd0, g}, 32'h4);
    step();
    check("t1_valid_e2", {31'd0, valid}, 32'd0);
    check("t1_pend_e2", {28'd0, pend}, 32'h0);

    // All four at once: g1..g4 in order with bubbles
    do_reset();
    ready = 1'b1; r_drv = 4'b1111;
    step();
    check("t2_pend_e0", {28'd0, pend}, 32'hF);
    r_drv = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_valid_g%0d", i + 1), {31'd0, valid}, 32'd1);
      check($sformatf("t2_g%0d", i + 1), {28'd0, g}, 32'(4'b0001 << i));
      step();
      check($sformatf("t2_bubble%0d", i + 1), {31'd0, valid}, 32'd0);
      check($sformatf("t2_pend%0d", i + 1), {28'd0, pend}, 32'(4'b1111 & (4'b1110 << i)));
    end
    check("t2_ovf", {31'd0, ovf}, 32'd0);

    // Hold r2 with ready low, pulse r1/r4, then g4 then g1
    do_reset();
    ready = 1'b0; r_drv = 4'b0010;
    step();
    r_drv = 4'b0000;
    step();
    check("t3_first_g", {28'd0, g}, 32'h2);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) r_drv = 4'b1001;
      if (c == 3) r_drv = 4'b0000;
      step();
      check($sformatf("t3_hold%0d", c), {27'd0, valid, g}, 32'h12);
    end
    check("t3_pend_held", {28'd0, pend}, 32'hB);
    ready = 1'b1;
    step();
    check("t3_acc_r2", {27'd0, valid, pend}, 32'h09);
    step();
    check("t3_g4", {28'd0, g}, 32'h8);
    step();
    check("t3_bubble", {31'd0, valid}, 32'd0);
    step();
    check("t3_g1", {28'd0, g}, 32'h1);
    step();
    check("t3_done", {27'd0, valid, pend}, 32'h00);

    // Overflow: second r1 edge while pend[0] set and not accepted
    do_reset();
    ready = 1'b0; r_drv = 4'b0010;
    step();
    r_drv = 4'b0000;
    step();
    r_drv = 4'b0001;
    step();
    check("t4_ovf_first", {31'd0, ovf}, 32'd0);
    r_drv = 4'b0000;
    step();
    r_drv = 4'b0001;
    step();
    check("t4_ovf_set", {31'd0, ovf}, 32'd1);
    r_drv = 4'b0000; ready = 1'b1;
    step(); step();
    check("t4_g1", {28'd0, g}, 32'h1);
    step();
    check("t4_ovf_sticky", {27'd0, ovf, pend}, 32'h10);

    // Accept and re-edge on r2 in the same cycle
    do_reset();
    check("t5_ovf_cleared", {31'd0, ovf}, 32'd0);
    ready = 1'b0; r_drv = 4'b0010;
    step();
    r_drv = 4'b0000;
    step();
    check("t5_g2", {28'd0, g}, 32'h2);
    ready = 1'b1; r_drv = 4'b0010;
    step();
    check("t5_set_wins", {26'd0, ovf, valid, pend}, 32'h02);
    r_drv = 4'b0000;
    step();
    check("t5_regrant", {27'd0, valid, g}, 32'h12);
    step();
    check("t5_done", {27'd0, valid, pend}, 32'h00);

    // Reset mid-grant with r1 held high
    do_reset();
    ready = 1'b0; r_drv = 4'b1000;
    step();
    r_drv = 4'b0000;
    step();
    check("t6_g4", {28'd0, g}, 32'h8);
    r_drv = 4'b0001;
    step();
    check("t6_pend", {28'd0, pend}, 32'h9);
    #2 rst = 1'b1;
    #1;
    check("t6_async_clear", {23'd0, valid, g, pend}, 32'h000);
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("t6_no_req", {27'd0, valid, pend}, 32'h00);
    r_drv = 4'b0000;
    step();
    r_drv = 4'b0001;
    step();
    check("t6_pend_new", {28'd0, pend}, 32'h1);
    step();
    check("t6_grant_new", {27'd0, valid, g}, 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
